axi_wr_slave: RTL and testbench

AXI4 write-path slave and consumer of the AW, W and B channels of the team's AXI interface (ADDR 16, DATA 32, ID 8).
- Accepts one burst at a time and converts each W beat into a registered word write on a simple SRAM port.
- Returns a single B response per burst.
- The read path is a separate block.

---
 rtl/axi_pkg.sv | 32 +++
 rtl/axi_burst_addr.sv | 40 ++++
 rtl/axi_wr_slave.sv | 197 +++++++++++++++++++
 tb/tb_axi_wr_slave.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write and read slaves: burst/response codes,
// write-path FSM states and default interface widths.
package axi_pkg;

   localparam int AXI_ADDR_W = 16;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_ID_W   = 8;
   localparam int AXI_MEM_AW = 12;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10,
      RSVD  = 2'b11
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DATA = 2'b01,
      RESP = 2'b10
   } wr_state_e;

   // WRAP bursts must span 2, 4, 8 or 16 beats
   function automatic logic wrapLenOk(input logic [7:0] len);
      return len inside {8'd1, 8'd3, 8'd7, 8'd15};
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address generator with burst legality flag,
// shared between the write slave and the read slave.
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = AXI_ADDR_W,
   parameter int STRB_WIDTH = AXI_DATA_W / 8
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [2:0]            size_i,
   input  logic [7:0]            len_i,
   input  logic [1:0]            burst_i,
   output logic [ADDR_WIDTH-1:0] next_addr_o,
   output logic                  illegal_o
);

   localparam int LANE_LOG = $clog2(STRB_WIDTH);

   logic [ADDR_WIDTH-1:0] bytes;
   logic [ADDR_WIDTH-1:0] total;
   logic [ADDR_WIDTH-1:0] mask;
   logic [ADDR_WIDTH-1:0] lo;

   // Legal WRAP totals are powers of two, so the modulo reduces to a mask
   always_comb begin
      bytes = ADDR_WIDTH'(1) << size_i;
      total = (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i;
      mask  = total - ADDR_WIDTH'(1);
      lo    = addr_i & ~mask;
      case (burst_i)
         FIXED:   next_addr_o = addr_i;
         INCR:    next_addr_o = addr_i + bytes;
         WRAP:    next_addr_o = lo + ((addr_i + bytes - lo) & mask);
         default: next_addr_o = addr_i + bytes;
      endcase
      illegal_o = (int'(size_i) > LANE_LOG) || (burst_i == RSVD) ||
                  ((burst_i == WRAP) && !wrapLenOk(len_i));
   end

endmodule

// File: rtl/axi_wr_slave.sv
// AXI4 write-path slave: one burst at a time, each W beat becomes a registered
// SRAM word write, one B response per burst. Define AXI_WR_WLAST_CHECK_EN to check wlast.
module axi_wr_slave
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = AXI_ADDR_W,
   parameter int DATA_WIDTH = AXI_DATA_W,
   parameter int ID_WIDTH   = AXI_ID_W,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int MEM_AW     = AXI_MEM_AW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_WIDTH-1:0]   awid,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [7:0]            awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [STRB_WIDTH-1:0] wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [ID_WIDTH-1:0]   bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   output logic                  mem_we,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [STRB_WIDTH-1:0] mem_wstrb
);

   localparam int LANE_LOG = $clog2(STRB_WIDTH);

   wr_state_e             state_q, state_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  slv_q, slv_d;
   logic                  dec_q, dec_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  memWe_q, memWe_d;
   logic [MEM_AW-1:0]     memAddr_q, memAddr_d;
   logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
   logic [STRB_WIDTH-1:0] memWstrb_q, memWstrb_d;

   logic [ADDR_WIDTH-1:0] nextAddr;
   logic                  illegal;
   logic [ADDR_WIDTH-1:0] wordIdx;
   logic                  outOfRange;
   logic                  burstErr;
   logic                  lastBeat;
   logic                  wlastErr;

   axi_burst_addr #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .STRB_WIDTH(STRB_WIDTH)
   ) uAddr (
      .addr_i     (addr_q),
      .size_i     (size_q),
      .len_i      (len_q),
      .burst_i    (burst_q),
      .next_addr_o(nextAddr),
      .illegal_o  (illegal)
   );

   assign wordIdx    = addr_q >> LANE_LOG;
   assign outOfRange = (wordIdx >> MEM_AW) != '0;

`ifndef AXI_WR_WLAST_CHECK_EN
   logic unusedWlast;
   assign unusedWlast = wlast;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         cnt_q      <= '0;
         slv_q      <= 1'b0;
         dec_q      <= 1'b0;
         bresp_q    <= RESP_OKAY;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         memWstrb_q <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         size_q     <= size_d;
         burst_q    <= burst_d;
         cnt_q      <= cnt_d;
         slv_q      <= slv_d;
         dec_q      <= dec_d;
         bresp_q    <= bresp_d;
         memWe_q    <= memWe_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
         memWstrb_q <= memWstrb_d;
      end
   end

   // slv_q holds only wlast errors; size/burst/len legality comes from the address unit
   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      addr_d     = addr_q;
      len_d      = len_q;
      size_d     = size_q;
      burst_d    = burst_q;
      cnt_d      = cnt_q;
      slv_d      = slv_q;
      dec_d      = dec_q;
      bresp_d    = bresp_q;
      memWe_d    = 1'b0;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      memWstrb_d = memWstrb_q;
      awready    = 1'b0;
      wready     = 1'b0;
      bvalid     = 1'b0;
      burstErr   = slv_q || illegal;
`ifdef AXI_WR_WLAST_CHECK_EN
      lastBeat   = (cnt_q == len_q) || wlast;
      wlastErr   = wlast != (cnt_q == len_q);
`else
      lastBeat   = cnt_q == len_q;
      wlastErr   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            awready = 1'b1;
            if (awvalid) begin
               id_d    = awid;
               addr_d  = awaddr;
               len_d   = awlen;
               size_d  = awsize;
               burst_d = awburst;
               cnt_d   = '0;
               slv_d   = 1'b0;
               dec_d   = 1'b0;
               state_d = DATA;
            end
         end
         DATA: begin
            wready = 1'b1;
            if (wvalid) begin
               memWe_d    = (wstrb != '0) && !burstErr && !outOfRange;
               memAddr_d  = wordIdx[MEM_AW-1:0];
               memWdata_d = wdata;
               memWstrb_d = wstrb;
               dec_d      = dec_q || outOfRange;
               slv_d      = slv_q || wlastErr;
               addr_d     = nextAddr;
               cnt_d      = cnt_q + 8'd1;
               if (lastBeat) begin
                  state_d = RESP;
                  if (slv_d || illegal) begin
                     bresp_d = RESP_SLVERR;
                  end else if (dec_d) begin
                     bresp_d = RESP_DECERR;
                  end else begin
                     bresp_d = RESP_OKAY;
                  end
               end
            end
         end
         RESP: begin
            bvalid = 1'b1;
            if (bready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bid       = id_q;
   assign bresp     = bresp_q;
   assign mem_we    = memWe_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign mem_wstrb = memWstrb_q;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Self-checking bench for axi_wr_slave (default build, wlast ignored): expected
// SRAM writes are queued as beats are driven and matched as mem_we pulses appear.
module tb_axi_wr_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  awid;
   logic [15:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [7:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   int checkCount = 0;
   int passCount  = 0;
   int cyc        = 0;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          cyc;
   } wrExp_t;

   wrExp_t expQ[$];
   wrExp_t monE;

   axi_wr_slave dut (
      .clk      (clk),
      .rst      (rst),
      .awid     (awid),
      .awaddr   (awaddr),
      .awlen    (awlen),
      .awsize   (awsize),
      .awburst  (awburst),
      .awvalid  (awvalid),
      .awready  (awready),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wlast    (wlast),
      .wvalid   (wvalid),
      .wready   (wready),
      .bid      (bid),
      .bresp    (bresp),
      .bvalid   (bvalid),
      .bready   (bready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Every SRAM write must match the oldest queued beat, including its cycle
   always @(negedge clk) begin
      if (mem_we !== 1'b0) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedWrite", {31'b0, mem_we}, 32'd0);
         end else begin
            monE = expQ.pop_front();
            checkOutput("memAddr", {20'b0, mem_addr}, {20'b0, monE.addr});
            checkOutput("memWdata", mem_wdata, monE.data);
            checkOutput("memWstrb", {28'b0, mem_wstrb}, {28'b0, monE.strb});
            checkOutput("writeCycle", cyc, monE.cyc);
         end
      end
   end

   // Reference address sequence written with plain integer arithmetic
   function automatic logic [15:0] modelNext(input logic [15:0] a, input int size, input int len, input int burst);
      int bytes, total, base, off;
      bytes = 1 << size;
      case (burst)
         0: return a;
         2: begin
            total = (len + 1) * bytes;
            base  = (int'(a) / total) * total;
            off   = (int'(a) - base + bytes) % total;
            return 16'(base + off);
         end
         default: return 16'((int'(a) + bytes) % 65536);
      endcase
   endfunction

   task automatic sendAw(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
      awid    = id;
      awaddr  = addr;
      awlen   = len;
      awsize  = size;
      awburst = burst;
      awvalid = 1'b1;
      for (int i = 0; i < 20 && awready !== 1'b1; i++) @(negedge clk);
      checkOutput("awHandshake", {31'b0, awready}, 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      checkOutput("awreadyInData", {31'b0, awready}, 32'd0);
   endtask

   task automatic sendBeat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                           input logic expWrite, input logic [11:0] expAddr);
      wdata  = data;
      wstrb  = strb;
      wlast  = last;
      wvalid = 1'b1;
      for (int i = 0; i < 20 && wready !== 1'b1; i++) @(negedge clk);
      checkOutput("wHandshake", {31'b0, wready}, 32'd1);
      if (expWrite) expQ.push_back('{expAddr, data, strb, cyc + 1});
      @(negedge clk);
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   // stall<0 raises bready before the burst so RESP lasts a single cycle
   task automatic applyStimulus(input string name, input logic [7:0] id, input logic [15:0] addr,
                                input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                                input logic [3:0] strb, input int lastAt, input int stall,
                                input logic [1:0] expResp);
      logic        slv;
      logic        oor;
      logic [15:0] a;
      int          widx;
      slv = (size > 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
      if (stall < 0) bready = 1'b1;
      sendAw(id, addr, len, size, burst);
      a = addr;
      for (int b = 0; b <= int'(len); b++) begin
         widx = int'(a) >> 2;
         oor  = widx >= 4096;
         sendBeat($urandom, strb, b == lastAt, (strb != 4'd0) && !slv && !oor, 12'(widx));
         a = modelNext(a, int'(size), int'(len), int'(burst));
      end
      checkOutput({name, ".bvalidRise"}, {31'b0, bvalid}, 32'd1);
      checkOutput({name, ".wreadyInResp"}, {31'b0, wready}, 32'd0);
      for (int i = 0; i < stall; i++) begin
         checkOutput({name, ".bvalidHeld"}, {31'b0, bvalid}, 32'd1);
         checkOutput({name, ".bidHeld"}, {24'b0, bid}, {24'b0, id});
         checkOutput({name, ".brespHeld"}, {30'b0, bresp}, {30'b0, expResp});
         checkOutput({name, ".awreadyInResp"}, {31'b0, awready}, 32'd0);
         @(negedge clk);
      end
      bready = 1'b1;
      checkOutput({name, ".bid"}, {24'b0, bid}, {24'b0, id});
      checkOutput({name, ".bresp"}, {30'b0, bresp}, {30'b0, expResp});
      @(negedge clk);
      bready = 1'b0;
      checkOutput({name, ".bvalidDrop"}, {31'b0, bvalid}, 32'd0);
      checkOutput({name, ".awreadyBack"}, {31'b0, awready}, 32'd1);
      @(negedge clk);
      checkOutput({name, ".pendingWrites"}, expQ.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rstAwready", {31'b0, awready}, 32'd1);
      checkOutput("rstWready", {31'b0, wready}, 32'd0);
      checkOutput("rstBvalid", {31'b0, bvalid}, 32'd0);
      checkOutput("rstBid", {24'b0, bid}, 32'd0);
      checkOutput("rstBresp", {30'b0, bresp}, 32'd0);
      checkOutput("rstMemWe", {31'b0, mem_we}, 32'd0);
      checkOutput("rstMemAddr", {20'b0, mem_addr}, 32'd0);
      checkOutput("rstMemWdata", mem_wdata, 32'd0);
      checkOutput("rstMemWstrb", {28'b0, mem_wstrb}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus("incr",     8'h5A, 16'h0010, 8'd3, 3'd2, 2'b01, 4'hF, 3, 0, 2'b00);
      applyStimulus("wrap",     8'h21, 16'h0018, 8'd3, 3'd2, 2'b10, 4'hF, 3, 0, 2'b00);
      applyStimulus("fixed",    8'h33, 16'h0040, 8'd2, 3'd2, 2'b00, 4'h5, 2, 0, 2'b00);
      applyStimulus("rsvd",     8'h44, 16'h0080, 8'd2, 3'd2, 2'b11, 4'hF, 2, 0, 2'b10);
      applyStimulus("decerr",   8'h55, 16'h3FFC, 8'd1, 3'd2, 2'b01, 4'hF, 1, 0, 2'b11);
      applyStimulus("stallB",   8'h66, 16'h0200, 8'd1, 3'd2, 2'b01, 4'h3, 1, 5, 2'b00);
      applyStimulus("preReady", 8'h67, 16'h0300, 8'd0, 3'd2, 2'b01, 4'hF, 0, -1, 2'b00);
      applyStimulus("zeroStrb", 8'h68, 16'h0500, 8'd1, 3'd2, 2'b01, 4'h0, 1, 0, 2'b00);
      applyStimulus("wideSize", 8'h69, 16'h0400, 8'd1, 3'd3, 2'b01, 4'hF, 1, 0, 2'b10);
      applyStimulus("wrapLen2", 8'h6A, 16'h0600, 8'd2, 3'd2, 2'b10, 4'hF, 2, 0, 2'b10);
      applyStimulus("earlyLast", 8'h6B, 16'h0700, 8'd3, 3'd2, 2'b01, 4'hF, 1, 0, 2'b00);

      // Reset mid-burst after two of four beats: nothing more may be written or answered
      sendAw(8'h77, 16'h0100, 8'd3, 3'd2, 2'b01);
      sendBeat($urandom, 4'hF, 1'b0, 1'b1, 12'h040);
      sendBeat($urandom, 4'hF, 1'b0, 1'b1, 12'h041);
      rst    = 1'b1;
      wvalid = 1'b1;
      wdata  = 32'hDEAD_BEEF;
      wstrb  = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midRstAwready", {31'b0, awready}, 32'd1);
      checkOutput("midRstMemWe", {31'b0, mem_we}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("midRstWready", {31'b0, wready}, 32'd0);
         checkOutput("midRstBvalid", {31'b0, bvalid}, 32'd0);
         @(negedge clk);
      end
      wvalid = 1'b0;
      checkOutput("midRstPending", expQ.size(), 32'd0);

      applyStimulus("afterRst", 8'h88, 16'h0020, 8'd1, 3'd2, 2'b01, 4'hC, 1, 0, 2'b00);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
